// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY symbol constants and the TX ordered-set scheduler state encoding.
package pcie_phy_pkg;

    localparam logic [7:0] SYM_COM       = 8'hBC;
    localparam logic [7:0] SYM_SKP       = 8'h1C;
    localparam logic [7:0] SYM_PAD       = 8'hF7;
    localparam logic [7:0] SYM_TS1_ID    = 8'h4A;
    localparam logic [7:0] SYM_RATE_GEN1 = 8'h02;
    localparam logic [7:0] SYM_IDLE      = 8'h00;

    // Index of the final symbol of each ordered set (COM is index 0).
    localparam logic [3:0] SKP_LAST_IDX  = 4'd3;
    localparam logic [3:0] TS1_LAST_IDX  = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_SKP  = 2'd2,
        ST_TS1  = 2'd3
    } os_state_e;

    function automatic logic sym_is_pad(input logic [7:0] sym);
        return (sym == SYM_PAD);
    endfunction

endpackage

// File: rtl/pcie_skp_timer.sv
// Counts non-ordered-set symbols and raises skp_pending once every SKP_INTERVAL of them.
module pcie_skp_timer #(
    parameter int SKP_INTERVAL = 1180
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic count_en,
    input  logic os_start,
    output logic skp_pending
);

    localparam int            CW       = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SKP_INTERVAL - 1);

    logic [CW-1:0] r_count;
    logic          r_pending;

    // An expiry while already pending only wraps the counter; the flag cannot stack a second SKP.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count   <= '0;
            r_pending <= 1'b0;
        end else if (count_en) begin
            if (r_count == CNT_LAST) begin
                r_count   <= '0;
                r_pending <= 1'b1;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end else if (os_start) begin
            r_pending <= 1'b0;
        end
    end

    assign skp_pending = r_pending;

endmodule

// File: rtl/pcie_tx_os_scheduler.sv
// Merges the MAC byte stream with SKP and TS1 ordered sets into one registered symbol stream.
module pcie_tx_os_scheduler
    import pcie_phy_pkg::*;
#(
    parameter int         SKP_INTERVAL = 1180,
    parameter logic [7:0] N_FTS        = 8'd255
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       data_valid_i,
    input  logic       data_last_i,
    output logic       data_ready_o,
    input  logic       ts1_req_i,
    input  logic [7:0] ts_link_i,
    input  logic [7:0] ts_lane_i,
    output logic [7:0] symbol_o,
    output logic       symbol_k_o,
    output logic       symbol_valid_o,
    input  logic       symbol_ready_i,
    output logic       is_ordered_set_o,
    output logic       bypass_scrambler_o,
    output os_state_e  dbg_state_o
);

    // Handshake: a symbol transfers on a rising edge with symbol_valid_o && symbol_ready_i;
    // the output register reloads only when empty or being consumed (w_adv), and a MAC byte
    // transfers on a rising edge with data_valid_i && data_ready_o.
    os_state_e  r_state;
    os_state_e  w_state_nxt;
    logic [3:0] r_idx;
    logic [3:0] w_idx_nxt;
    logic [7:0] r_link;
    logic [7:0] r_lane;
    logic [7:0] w_link_nxt;
    logic [7:0] w_lane_nxt;

    logic [7:0] r_sym;
    logic       r_k;
    logic       r_valid;
    logic       r_os;
    logic       r_bypass;
    logic [7:0] w_sym;
    logic       w_k;
    logic       w_valid;
    logic       w_os;

    logic       w_adv;
    logic       w_accept;
    logic       w_count;
    logic       w_os_start;
    logic       w_count_en;
    logic       w_skp_start;
    logic       w_skp_pending;

    assign w_adv = !r_valid || symbol_ready_i;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_link_nxt  = r_link;
        w_lane_nxt  = r_lane;
        w_sym       = SYM_IDLE;
        w_k         = 1'b0;
        w_os        = 1'b0;
        w_valid     = 1'b1;
        w_accept    = 1'b0;
        w_count     = 1'b0;
        w_os_start  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_skp_pending) begin
                    w_sym       = SYM_COM;
                    w_k         = 1'b1;
                    w_os        = 1'b1;
                    w_os_start  = 1'b1;
                    w_idx_nxt   = 4'd1;
                    w_state_nxt = ST_SKP;
                end else if (ts1_req_i) begin
                    w_sym       = SYM_COM;
                    w_k         = 1'b1;
                    w_os        = 1'b1;
                    w_link_nxt  = ts_link_i;
                    w_lane_nxt  = ts_lane_i;
                    w_idx_nxt   = 4'd1;
                    w_state_nxt = ST_TS1;
                end else if (data_valid_i) begin
                    w_sym    = data_i;
                    w_accept = 1'b1;
                    w_count  = 1'b1;
                    if (!data_last_i) begin
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_count = 1'b1;
                end
            end
            ST_DATA: begin
                if (data_valid_i) begin
                    w_sym    = data_i;
                    w_accept = 1'b1;
                    w_count  = 1'b1;
                    if (data_last_i) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_valid = 1'b0;
                end
            end
            ST_SKP: begin
                w_sym     = SYM_SKP;
                w_k       = 1'b1;
                w_os      = 1'b1;
                w_idx_nxt = r_idx + 4'd1;
                if (r_idx == SKP_LAST_IDX) begin
                    w_idx_nxt   = 4'd0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_TS1: begin
                w_os      = 1'b1;
                w_idx_nxt = r_idx + 4'd1;
                case (r_idx)
                    4'd1: begin
                        w_sym = r_link;
                        w_k   = sym_is_pad(r_link);
                    end
                    4'd2: begin
                        w_sym = r_lane;
                        w_k   = sym_is_pad(r_lane);
                    end
                    4'd3:    w_sym = N_FTS;
                    4'd4:    w_sym = SYM_RATE_GEN1;
                    4'd5:    w_sym = SYM_IDLE;
                    default: w_sym = SYM_TS1_ID;
                endcase
                // A started TS1 always runs to completion regardless of ts1_req_i.
                if (r_idx == TS1_LAST_IDX) begin
                    w_idx_nxt   = 4'd0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_valid     = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state  <= ST_IDLE;
            r_idx    <= 4'd0;
            r_link   <= 8'h00;
            r_lane   <= 8'h00;
            r_sym    <= 8'h00;
            r_k      <= 1'b0;
            r_valid  <= 1'b0;
            r_os     <= 1'b0;
            r_bypass <= 1'b0;
        end else if (w_adv) begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_link   <= w_link_nxt;
            r_lane   <= w_lane_nxt;
            r_sym    <= w_sym;
            r_k      <= w_k;
            r_valid  <= w_valid;
            r_os     <= w_os;
            r_bypass <= w_os;
        end
    end

    assign w_count_en  = w_adv && w_count;
    assign w_skp_start = w_adv && w_os_start;

    pcie_skp_timer #(
        .SKP_INTERVAL(SKP_INTERVAL)
    ) u_skp_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .count_en   (w_count_en),
        .os_start   (w_skp_start),
        .skp_pending(w_skp_pending)
    );

    assign data_ready_o       = rst_i && w_adv && w_accept;
    assign symbol_o           = r_sym;
    assign symbol_k_o         = r_k;
    assign symbol_valid_o     = r_valid;
    assign is_ordered_set_o   = r_os;
    assign bypass_scrambler_o = r_bypass;
    assign dbg_state_o        = r_state;

endmodule

// File: tb/tb_pcie_tx_os_scheduler.sv
// Randomised scoreboard bench for pcie_tx_os_scheduler against a symbol-stream reference model.
module tb_pcie_tx_os_scheduler;
    import pcie_phy_pkg::*;

    localparam int SKP_I = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       data_valid_i = 1'b0;
    logic       data_last_i = 1'b0;
    logic       data_ready_o;
    logic       ts1_req_i = 1'b0;
    logic [7:0] ts_link_i = 8'h00;
    logic [7:0] ts_lane_i = 8'h00;
    logic [7:0] symbol_o;
    logic       symbol_k_o;
    logic       symbol_valid_o;
    logic       symbol_ready_i = 1'b1;
    logic       is_ordered_set_o;
    logic       bypass_scrambler_o;
    os_state_e  dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference model state; expected entries are {os, k, symbol}.
    logic [9:0] exp_q[$];
    logic [9:0] os_q[$];
    bit         m_valid = 1'b0;
    bit         m_in_pkt = 1'b0;
    bit         m_pend = 1'b0;
    int         m_cnt = 0;
    int         ts1_starts = 0;
    logic [7:0] pkt_q[$];
    int         ts1_hold = 0;

    pcie_tx_os_scheduler #(
        .SKP_INTERVAL(SKP_I),
        .N_FTS       (8'd255)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst_n),
        .data_i            (data_i),
        .data_valid_i      (data_valid_i),
        .data_last_i       (data_last_i),
        .data_ready_o      (data_ready_o),
        .ts1_req_i         (ts1_req_i),
        .ts_link_i         (ts_link_i),
        .ts_lane_i         (ts_lane_i),
        .symbol_o          (symbol_o),
        .symbol_k_o        (symbol_k_o),
        .symbol_valid_o    (symbol_valid_o),
        .symbol_ready_i    (symbol_ready_i),
        .is_ordered_set_o  (is_ordered_set_o),
        .bypass_scrambler_o(bypass_scrambler_o),
        .dbg_state_o       (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic tick_nonos();
        m_cnt++;
        if (m_cnt == SKP_I) begin
            m_cnt  = 0;
            m_pend = 1'b1;
        end
    endtask

    task automatic emit_data();
        exp_q.push_back({2'b00, data_i});
        tick_nonos();
        m_in_pkt = !data_last_i;
    endtask

    task automatic build_ts1();
        os_q.push_back({2'b11, 8'hBC});
        os_q.push_back({1'b1, (ts_link_i == 8'hF7), ts_link_i});
        os_q.push_back({1'b1, (ts_lane_i == 8'hF7), ts_lane_i});
        os_q.push_back({2'b10, 8'hFF});
        os_q.push_back({2'b10, 8'h02});
        os_q.push_back({2'b10, 8'h00});
        for (int i = 0; i < 10; i++) os_q.push_back({2'b10, 8'h4A});
    endtask

    initial begin : ref_model
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_valid  = 1'b0;
                m_in_pkt = 1'b0;
                m_pend   = 1'b0;
                m_cnt    = 0;
                os_q.delete();
                exp_q.delete();
            end else if (!m_valid || symbol_ready_i) begin
                m_valid = 1'b1;
                if (os_q.size() > 0) begin
                    exp_q.push_back(os_q.pop_front());
                end else if (m_in_pkt) begin
                    if (data_valid_i) emit_data();
                    else m_valid = 1'b0;
                end else if (m_pend) begin
                    m_pend = 1'b0;
                    os_q.push_back({2'b11, 8'hBC});
                    for (int i = 0; i < 3; i++) os_q.push_back({2'b11, 8'h1C});
                    exp_q.push_back(os_q.pop_front());
                end else if (ts1_req_i) begin
                    build_ts1();
                    ts1_starts++;
                    exp_q.push_back(os_q.pop_front());
                end else if (data_valid_i) begin
                    emit_data();
                end else begin
                    exp_q.push_back({2'b00, 8'h00});
                    tick_nonos();
                end
            end
        end
    end

    function automatic logic pred_ready();
        return rst_n && (!m_valid || symbol_ready_i) && (os_q.size() == 0) && data_valid_i &&
               (m_in_pkt || (!m_pend && !ts1_req_i));
    endfunction

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic [9:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                chk("symbol_valid", symbol_valid_o, m_valid);
                chk("data_ready", data_ready_o, pred_ready());
                if (symbol_valid_o && symbol_ready_i) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL symbol_unexpected: got %0h with no expected symbol at %0t",
                                 symbol_o, $time);
                    end else begin
                        e = exp_q.pop_front();
                        if ({is_ordered_set_o, bypass_scrambler_o, symbol_k_o, symbol_o} !==
                            {e[9], e[9], e[8], e[7:0]}) begin
                            errors++;
                            $display("FAIL symbol: got os=%0b byp=%0b k=%0b sym=%02h expected os=%0b byp=%0b k=%0b sym=%02h at %0t",
                                     is_ordered_set_o, bypass_scrambler_o, symbol_k_o, symbol_o,
                                     e[9], e[9], e[8], e[7:0], $time);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check_outputs_zero(input string tag);
        chk({tag, "_symbol"}, symbol_o, 8'h00);
        chk({tag, "_k"}, symbol_k_o, 1'b0);
        chk({tag, "_valid"}, symbol_valid_o, 1'b0);
        chk({tag, "_os"}, is_ordered_set_o, 1'b0);
        chk({tag, "_bypass"}, bypass_scrambler_o, 1'b0);
        chk({tag, "_data_ready"}, data_ready_o, 1'b0);
    endtask

    task automatic drive_pkt();
        int guard;
        guard = 0;
        while (pkt_q.size() > 0 && guard < 500) begin
            @(negedge clk);
            data_valid_i = 1'b1;
            data_i       = pkt_q[0];
            data_last_i  = (pkt_q.size() == 1);
            #1;
            if (data_ready_o) void'(pkt_q.pop_front());
            guard++;
        end
        chk("pkt_timeout", pkt_q.size(), 0);
        @(negedge clk);
        data_valid_i = 1'b0;
        data_last_i  = 1'b0;
    endtask

    task automatic start_ts1(input logic [7:0] link, input logic [7:0] lane);
        int base;
        int n;
        base = ts1_starts;
        n    = 0;
        ts_link_i = link;
        ts_lane_i = lane;
        ts1_req_i = 1'b1;
        while (ts1_starts == base && n < 200) begin
            @(negedge clk);
            n++;
        end
        ts1_req_i = 1'b0;
        chk("ts1_started", (ts1_starts != base), 1'b1);
    endtask

    task automatic wait_os_sym(input logic [7:0] val);
        int  n;
        bit  found;
        n     = 0;
        found = 1'b0;
        while (!found && n < 50) begin
            @(negedge clk);
            if (symbol_valid_o && is_ordered_set_o && symbol_o == val) found = 1'b1;
            n++;
        end
        chk("wait_ts1_sym1", found, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin : driver
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Idle link: eight idle symbols between SKP sets.
        repeat (30) @(negedge clk);

        pkt_q = '{8'h11, 8'h22, 8'h33};
        drive_pkt();
        repeat (5) @(negedge clk);

        // Long packet: SKP must wait for the last byte.
        for (int i = 0; i < 20; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
        drive_pkt();
        repeat (10) @(negedge clk);

        start_ts1(8'hF7, 8'hF7);
        repeat (30) @(negedge clk);

        // Stall five cycles while TS1 symbol 7 is on the output.
        start_ts1(8'hF7, 8'hF7);
        wait_os_sym(8'hF7);
        repeat (6) @(negedge clk);
        symbol_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_hold", {symbol_valid_o, is_ordered_set_o, symbol_o}, {2'b11, 8'h4A});
            @(negedge clk);
        end
        symbol_ready_i = 1'b1;
        repeat (30) @(negedge clk);

        // Random traffic with backpressure, gaps, and TS1 requests.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            symbol_ready_i = ($urandom_range(0, 3) != 0);
            if (pkt_q.size() == 0 && $urandom_range(0, 15) == 0) begin
                int len;
                len = $urandom_range(1, 12);
                for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom_range(0, 255)));
            end
            data_valid_i = (pkt_q.size() > 0) && ($urandom_range(0, 3) != 0);
            data_i       = (pkt_q.size() > 0) ? pkt_q[0] : 8'h00;
            data_last_i  = (pkt_q.size() == 1);
            if (ts1_hold == 0 && $urandom_range(0, 40) == 0) ts1_hold = $urandom_range(1, 20);
            ts1_req_i = (ts1_hold > 0);
            if (ts1_hold > 0) ts1_hold--;
            ts_link_i = ($urandom_range(0, 3) == 0) ? 8'hF7 : 8'($urandom_range(0, 255));
            ts_lane_i = ($urandom_range(0, 3) == 0) ? 8'hF7 : 8'($urandom_range(0, 255));
            #1;
            if (data_valid_i && data_ready_o) void'(pkt_q.pop_front());
        end
        @(negedge clk);
        ts1_req_i      = 1'b0;
        symbol_ready_i = 1'b1;
        drive_pkt();
        repeat (30) @(negedge clk);

        // Reset while TS1 symbol 9 is on the output.
        start_ts1(8'h05, 8'h06);
        wait_os_sym(8'h05);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("mid_ts1_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);

        chk("exp_q_drained", (exp_q.size() <= 1), 1'b1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pcie_tx_os_scheduler.md
PCIE_TX_OS_SCHEDULER -- requirements
Module: pcie_tx_os_scheduler

Interface
REQ-001 SHALL have parameter SKP_INTERVAL, default 1180: non-OS symbols sent between SKP ordered sets.
REQ-002 SHALL have parameter N_FTS, default 8'd255: value placed in TS1 symbol 3.
REQ-003 SHALL have port clk_i, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port data_i, input, 8: data-stream byte from the MAC.
REQ-006 SHALL have port data_valid_i, input, 1: data_i is valid.
REQ-007 SHALL have port data_last_i, input, 1: data_i is the last byte of a packet.
REQ-008 SHALL have port data_ready_o, output, 1: the byte is accepted this cycle.
REQ-009 SHALL have port ts1_req_i, input, 1: level request from pcie_controller to send TS1s.
REQ-010 SHALL have port ts_link_i, input, 8, and port ts_lane_i, input, 8: TS1 link and lane numbers.
REQ-011 SHALL have port symbol_o, output, 8, and port symbol_k_o, output, 1: symbol to multi_lane_controller and its K-code flag.
REQ-012 SHALL have port symbol_valid_o, output, 1, and port symbol_ready_i, input, 1: output handshake.
REQ-013 SHALL have port is_ordered_set_o, output, 1, and port bypass_scrambler_o, output, 1: ordered-set and scrambler-bypass qualifiers for symbol_o.

Function
REQ-014 SHALL register all outputs; the stage advances ("adv") when !symbol_valid_o || symbol_ready_i.
REQ-015 SHALL hold all outputs stable while symbol_valid_o=1 && symbol_ready_i=0.
REQ-016 SHALL implement FSM states IDLE, DATA, SKP, TS1.
REQ-017 SHALL, in IDLE on adv, pick the next stream by priority: skp_pending, then ts1_req_i, then data_valid_i.
REQ-018 SHALL, in IDLE on adv with nothing to send, emit logical idle: 8'h00, K=0, OS=0, bypass=0.
REQ-019 SHALL assert data_ready_o only on adv while in IDLE-selecting-data or in DATA; the accepted byte appears on symbol_o next cycle with K=0, OS=0, bypass=0.
REQ-020 SHALL stay in DATA until the byte with data_last_i is accepted; SKP and TS1 SHALL never interrupt a packet.
REQ-021 SHALL, in DATA with data_valid_i=0, emit no symbol (symbol_valid_o=0) and stay in DATA.
REQ-022 SHALL, in SKP, emit 4 symbols: 8'hBC (COM), then 8'h1C (SKP) three times; all K=1, OS=1, bypass=1; then return to IDLE.
REQ-023 SHALL, in TS1, emit 16 symbols: 8'hBC (K=1); ts_link_i; ts_lane_i; N_FTS; 8'h02; 8'h00; then 8'h4A ten times; OS=1 and bypass=1 throughout.
REQ-024 SHALL send ts_link_i or ts_lane_i equal to 8'hF7 (PAD) with K=1.
REQ-025 SHALL sample ts_link_i and ts_lane_i when the COM symbol is emitted.
REQ-026 SHALL always complete a started TS1, even if ts1_req_i falls mid-set.
REQ-027 SHALL, after a TS1, return to IDLE and re-apply REQ-017, so TS1s repeat back-to-back while ts1_req_i stays high and no SKP is pending.
REQ-028 SHALL have a skp counter that increments on each emitted non-OS symbol (data or idle) accepted by adv.
REQ-029 SHALL, when the counter reaches SKP_INTERVAL-1 and that symbol is accepted, set skp_pending and clear the counter.
REQ-030 SHALL clear skp_pending when the SKP COM is emitted.
REQ-031 SHALL hold the skp counter during SKP and TS1.
REQ-032 SHALL not count a second expiry while skp_pending=1 (no double SKP).
REQ-033 SHALL size the counter at $clog2(SKP_INTERVAL) bits and compare in that width.

Reset
REQ-034 SHALL, on rst_i low, immediately force: FSM to IDLE; counters and skp_pending to 0; symbol_o=0, symbol_k_o=0, symbol_valid_o=0, is_ordered_set_o=0, bypass_scrambler_o=0, data_ready_o=0.
REQ-035 SHALL abort any ordered set or packet in progress on reset, with no resume.
REQ-036 SHALL deassert reset synchronously (2-flop synchroniser at top level, outside this block).

Structure
REQ-037 SHALL keep symbol constants (COM, SKP, PAD, TS1_ID, RATE_GEN1) and the FSM state enum in shared package pcie_phy_pkg.
REQ-038 SHALL place the skp counter and pending logic in sub-module pcie_skp_timer (ports: clk_i, rst_i, count_en, os_start, skp_pending).
REQ-039 SHALL keep the rest (FSM, OS sequencer, output register) in this module, 120-400 RTL lines.

Verification
REQ-040 SHALL test: 3-byte packet {11,22,33} with last on 33 and ready=1 -> symbols 11,22,33 on consecutive cycles, K=0, OS=0.
REQ-041 SHALL test: SKP_INTERVAL=8, idle link -> 8 symbols of 00, then BC,1C,1C,1C with OS=1 and bypass=1, repeating.
REQ-042 SHALL test: SKP_INTERVAL=8, 20-byte packet -> SKP deferred until after the last byte, then BC,1C,1C,1C.
REQ-043 SHALL test: ts1_req_i pulsed 1 cycle, link=F7, lane=F7 -> one full TS1 of BC,F7(K),F7(K),FF,02,00,4Ax10.
REQ-044 SHALL test: symbol_ready_i low for 5 cycles mid-TS1 at symbol 7 -> symbol 7 held, no symbol lost or duplicated.
REQ-045 SHALL test: rst_i low at TS1 symbol 9 -> outputs 0 at once; after release, idle 00 symbols and the counter restarts at 0.
